div_seq: RTL and testbench

Sequential 32-bit signed integer divider for the processor's multiply/divide path. It is the inverse counterpart of the bitwise-AND/partial-product datapath used for multiplication. The divider runs a restoring shift-subtract loop, producing one quotient bit per cycle. The execute stage starts it with a one-cycle request pulse and stalls until the ready pulse arrives.

---
 rtl/div_seq_if.sv | 25 ++
 rtl/div_seq.sv | 142 ++++++++++++++
 tb/tb_div_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Request/result bundle between the execute stage and the sequential divider.
// Handshake: the master pulses ctrl_DIV for one cycle with operands valid on that edge; the slave answers with a one-cycle data_resultRDY, and result/remainder/exception stay valid from that pulse until the next request.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy, dbg_state
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy, dbg_state
  );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract signed divider: one quotient bit per cycle on magnitudes,
// sign correction in FIX, one-cycle ready pulse in DONE.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remout_q, remout_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // 33-bit magnitudes keep |-2^WIDTH-1| representable
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign a_ext   = {bus.data_operandA[WIDTH-1], bus.data_operandA};
  assign b_ext   = {bus.data_operandB[WIDTH-1], bus.data_operandB};
  assign a_mag   = bus.data_operandA[WIDTH-1] ? -a_ext : a_ext;
  assign b_mag   = bus.data_operandB[WIDTH-1] ? -b_ext : b_ext;
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, div_q};

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Divide-by-zero skips RUN and settles in FIX so its ready pulse lands one cycle after the request.
  always_comb begin
    state_d = state_q;
    if (bus.ctrl_DIV) begin
      state_d = (bus.data_operandB == '0) ? FIX : RUN;
    end else begin
      case (state_q)
        RUN:     if (count_q == CW'(WIDTH-1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    remout_d  = remout_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    if (bus.ctrl_DIV) begin
      quo_d     = a_mag[WIDTH-1:0];
      div_d     = b_mag[WIDTH-1:0];
      rem_d     = '0;
      count_d   = '0;
      neg_rem_d = bus.data_operandA[WIDTH-1];
      neg_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz_d      = (bus.data_operandB == '0);
    end else begin
      case (state_q)
        RUN: begin
          if (!trial[WIDTH+1]) rem_d = trial[WIDTH:0];
          else                 rem_d = shifted;
          quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
          count_d = count_q + CW'(1);
        end
        FIX: begin
          rdy_d = 1'b1;
          if (dz_q) begin
            result_d = '0;
            remout_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_quo_q ? -quo_q : quo_q;
            remout_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            exc_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      remout_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      remout_q  <= remout_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = remout_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotients, latency, abort and reset behaviour.
module tb_div_seq;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_DIV      = 1'b0;
  endtask

  // Called half a cycle after the request edge; returns cycles until ready is seen.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_e);
    int lat;
    start_div(a, b);
    wait_rdy(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_quo"}, bus.data_result, exp_q);
    check_eq({tag, "_rem"}, bus.data_remainder, exp_r);
    check_eq({tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, exp_e});
    check_eq({tag, "_busy_at_rdy"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clock);
    check_eq({tag, "_rdy_pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
    check_eq({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_quo_hold"}, bus.data_result, exp_q);
  endtask

  initial begin
    int rdy_cnt;
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_quo",  bus.data_result, 32'd0);
    check_eq("rst_rem",  bus.data_remainder, 32'd0);
    check_eq("rst_exc",  {31'd0, bus.data_exception}, 32'd0);
    check_eq("rst_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;

    run_case("p100_p7",   32'd100,          32'd7,          33, 32'd14,         32'd2,          1'b0);
    run_case("m100_p7",   32'hFFFF_FF9C,    32'd7,          33, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    run_case("p100_m7",   32'd100,          32'hFFFF_FFF9,  33, 32'hFFFF_FFF2,  32'd2,          1'b0);
    run_case("m7_m2",     32'hFFFF_FFF9,    32'hFFFF_FFFE,  33, 32'd3,          32'hFFFF_FFFF,  1'b0);
    run_case("div0",      32'd5,            32'd0,          1,  32'd0,          32'd0,          1'b1);
    run_case("p9_p3",     32'd9,            32'd3,          33, 32'd3,          32'd0,          1'b0);
    run_case("min_m1",    32'h8000_0000,    32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0,          1'b0);
    run_case("min_p1",    32'h8000_0000,    32'd1,          33, 32'h8000_0000,  32'd0,          1'b0);

    // Restart mid-run: only the second request may produce a ready pulse.
    start_div(32'd1000, 32'd10);
    repeat (13) @(negedge clock);
    run_case("abort_81_9", 32'd81, 32'd9, 33, 32'd9, 32'd0, 1'b0);

    // Reset mid-run clears everything and suppresses the ready pulse.
    start_div(32'd1000, 32'd10);
    repeat (18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_quo",  bus.data_result, 32'd0);
    check_eq("midrst_rem",  bus.data_remainder, 32'd0);
    check_eq("midrst_exc",  {31'd0, bus.data_exception}, 32'd0);
    check_eq("midrst_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) rdy_cnt++;
    end
    check_eq("midrst_no_rdy", 32'(rdy_cnt), 32'd0);
    run_case("p7_p2", 32'd7, 32'd2, 33, 32'd3, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
